// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if: ID-side request and hazard-control response bundle for pipe_hazard_unit.
//
// Request (driven by the ID stage / bench, "master"):
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwrite, id_is_load,
//   redirect (taken branch/jump resolved this cycle), mem_ready (data memory ready).
// Response (driven by the hazard unit, "slave"):
//   stall_if, stall_id, bubble_ex, flush_ifid, mem_hold, fwd_sel_a, fwd_sel_b, stall_cnt.
interface pipe_hazard_unit_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned SEL_W  = 2
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_is_load;
   logic              redirect;
   logic              mem_ready;

   logic              stall_if;
   logic              stall_id;
   logic              bubble_ex;
   logic              flush_ifid;
   logic              mem_hold;
   logic [SEL_W-1:0]  fwd_sel_a;
   logic [SEL_W-1:0]  fwd_sel_b;
   logic [31:0]       stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwrite,
             id_is_load, redirect, mem_ready,
      input  stall_if, stall_id, bubble_ex, flush_ifid, mem_hold, fwd_sel_a, fwd_sel_b,
             stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwrite,
             id_is_load, redirect, mem_ready,
      output stall_if, stall_id, bubble_ex, flush_ifid, mem_hold, fwd_sel_a, fwd_sel_b,
             stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard and scoreboard controller sitting beside the ID stage.
//
// Tracks in-flight register writes of the DEPTH post-ID stages (stage 1 = EX ... stage
// DEPTH = WB) in a registered scoreboard and derives, combinationally and with zero latency,
// load-use / no-forwarding stalls, forwarding selects, redirect flushes and memory-wait holds.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; clears the scoreboard and stall_cnt
//   hz     pipe_hazard_unit_if.slave: ID request in, stall/flush/forward controls out
//
// Parameters:
//   DEPTH          post-ID stages tracked
//   REG_AW         register address width
//   LOAD_STAGE     first stage whose output carries load data
//   REDIRECT_STAGE stage in which branch/jump redirects resolve
//   FWD_EN         1 = forward from any stage, 0 = stall on every RAW hazard
//   SEL_W          forwarding select width, 2**SEL_W must exceed DEPTH
module pipe_hazard_unit #(
   parameter int unsigned DEPTH          = 3,
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned LOAD_STAGE     = 2,
   parameter int unsigned REDIRECT_STAGE = 2,
   parameter int unsigned FWD_EN         = 1,
   parameter int unsigned SEL_W          = 2
) (
   input logic             clk,
   input logic             reset,
   pipe_hazard_unit_if.slave hz
);

   typedef struct packed {
      logic             hit;
      logic [SEL_W-1:0] stage;
      logic             ld;
   } match_t;

   // Scoreboard: index i mirrors stage i+1.
   logic [DEPTH-1:0]             v_q, v_d;
   logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
   logic [DEPTH-1:0]             ld_q, ld_d;
   logic [31:0]                  cnt_q, cnt_d;

   match_t match_a, match_b;
   logic   hz_a, hz_b, hazard;

   // Youngest producer wins: scan oldest to youngest so the smallest stage overwrites.
   function automatic match_t find_producer(input logic [REG_AW-1:0]           rs,
                                            input logic                        used,
                                            input logic [DEPTH-1:0]             v,
                                            input logic [DEPTH-1:0][REG_AW-1:0] rd,
                                            input logic [DEPTH-1:0]             ld);
      match_t m;
      m = '0;
      if (used && (rs != '0)) begin
         for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (v[i] && (rd[i] == rs)) begin
               m.hit   = 1'b1;
               m.stage = SEL_W'(i + 1);
               m.ld    = ld[i];
            end
         end
      end
      return m;
   endfunction

   function automatic logic src_hazard(input match_t m);
      logic h;
      if (FWD_EN != 0) begin
         // Only a load whose data is not yet available in its stage forces a stall.
         h = m.hit && m.ld && (32'(m.stage) < LOAD_STAGE);
      end else begin
         // RF write happens at the WB edge, so even a stage-DEPTH match must wait.
         h = m.hit;
      end
      return h;
   endfunction

   always_comb begin
      match_a = find_producer(hz.id_rs1, hz.id_rs1_used, v_q, rd_q, ld_q);
      match_b = find_producer(hz.id_rs2, hz.id_rs2_used, v_q, rd_q, ld_q);
      hz_a    = src_hazard(match_a);
      hz_b    = src_hazard(match_b);
      hazard  = hz.id_valid && (hz_a || hz_b);
   end

   // Control outputs: mem_ready=0 dominates, then redirect, then RAW hazard.
   always_comb begin
      hz.stall_if   = 1'b0;
      hz.stall_id   = 1'b0;
      hz.bubble_ex  = 1'b0;
      hz.flush_ifid = 1'b0;
      hz.mem_hold   = 1'b0;
      if (!hz.mem_ready) begin
         hz.mem_hold = 1'b1;
         hz.stall_if = 1'b1;
         hz.stall_id = 1'b1;
      end else if (hz.redirect) begin
         hz.flush_ifid = 1'b1;
         hz.bubble_ex  = 1'b1;
      end else if (hazard) begin
         hz.stall_if  = 1'b1;
         hz.stall_id  = 1'b1;
         hz.bubble_ex = 1'b1;
      end
   end

   // Forwarding selects stay live during a memory hold, computed from the frozen scoreboard.
   always_comb begin
      hz.fwd_sel_a = '0;
      hz.fwd_sel_b = '0;
      if ((FWD_EN != 0) && hz.id_valid) begin
         if (match_a.hit && !hz_a) hz.fwd_sel_a = match_a.stage;
         if (match_b.hit && !hz_b) hz.fwd_sel_b = match_b.stage;
      end
   end

   // Scoreboard next state. A redirect kills wrong-path entries younger than the
   // resolving stage while older entries keep advancing.
   always_comb begin
      v_d  = v_q;
      rd_d = rd_q;
      ld_d = ld_q;
      if (hz.mem_ready) begin
         for (int unsigned i = DEPTH - 1; i >= 1; i--) begin
            v_d[i]  = v_q[i-1] && !(hz.redirect && (i < REDIRECT_STAGE));
            rd_d[i] = rd_q[i-1];
            ld_d[i] = ld_q[i-1];
         end
         v_d[0]  = hz.id_valid && hz.id_regwrite && (hz.id_rd != '0) && !hazard &&
                   !hz.redirect;
         rd_d[0] = hz.id_rd;
         ld_d[0] = hz.id_is_load;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (hz.stall_id && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
   end

   assign hz.stall_cnt = cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_q   <= '0;
         rd_q  <= '0;
         ld_q  <= '0;
         cnt_q <= '0;
      end else begin
         v_q   <= v_d;
         rd_q  <= rd_d;
         ld_q  <= ld_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
